// File: rtl/cache_pkg.sv
// Shared types and width/field helpers for the 2-way write-back cache.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } cache_state_e;

  function automatic int tag_width(input int addr_w, input int set_bits, input int off_bits);
    return addr_w - set_bits - off_bits;
  endfunction

  function automatic int line_width(input int word_w, input int off_bits);
    return word_w << off_bits;
  endfunction

  // Extract a width-bit field starting at lsb; caller casts down to the field width.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Miss victim choice: first invalid way (way0 first), otherwise the LRU way.
module cache_victim_sel (
  input  logic [1:0] i_valid,
  input  logic [1:0] i_dirty,
  input  logic       i_lru,
  output logic       o_victim,
  output logic       o_needs_wb
);

  always_comb begin
    if (!i_valid[0])      o_victim = 1'b0;
    else if (!i_valid[1]) o_victim = 1'b1;
    else                  o_victim = i_lru;
  end

  assign o_needs_wb = i_valid[o_victim] & i_dirty[o_victim];

endmodule

// File: rtl/cache_sa2_wb.sv
// 2-way set-associative write-back/write-allocate cache with a line-wide memory port.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_sa2_wb
  import cache_pkg::*;
#(
  parameter  int WORD_W   = 16,
  parameter  int ADDR_W   = 16,
  parameter  int SET_BITS = 1,
  parameter  int OFF_BITS = 2,
  localparam int LINE_W   = line_width(WORD_W, OFF_BITS)
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef CACHE_STATS_EN
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
`endif
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ready,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rd_ack,
  input  logic              mem_wr_ack
);

  localparam int TAG_W = tag_width(ADDR_W, SET_BITS, OFF_BITS);
  localparam int SETS  = 1 << SET_BITS;

  cache_state_e r_state, w_state_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_cpu_ready;
  logic [WORD_W-1:0] r_cpu_rdata;
  logic              r_victim;

  logic [SETS-1:0]   r_valid [2];
  logic [SETS-1:0]   r_dirty [2];
  logic [SETS-1:0]   r_lru;
  logic [TAG_W-1:0]  r_tag   [2][SETS];
  logic [LINE_W-1:0] r_data  [2][SETS];

  logic [OFF_BITS-1:0] w_off;
  logic [SET_BITS-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [1:0]          w_way_hit;
  logic [1:0]          w_set_valid;
  logic [1:0]          w_set_dirty;
  logic                w_hit;
  logic                w_hit_way;
  logic [LINE_W-1:0]   w_hit_line;
  logic                w_victim;
  logic                w_needs_wb;

  assign w_off = OFF_BITS'(addr_field(32'(r_addr), 0, OFF_BITS));
  assign w_idx = SET_BITS'(addr_field(32'(r_addr), OFF_BITS, SET_BITS));
  assign w_tag = TAG_W'(addr_field(32'(r_addr), OFF_BITS + SET_BITS, TAG_W));

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      assign w_set_valid[gi] = r_valid[gi][w_idx];
      assign w_set_dirty[gi] = r_dirty[gi][w_idx];
      assign w_way_hit[gi]   = r_valid[gi][w_idx] && (r_tag[gi][w_idx] == w_tag);
    end
  endgenerate

  assign w_hit      = |w_way_hit;
  assign w_hit_way  = w_way_hit[1];
  assign w_hit_line = r_data[w_hit_way][w_idx];

  cache_victim_sel u_victim_sel (
    .i_valid    (w_set_valid),
    .i_dirty    (w_set_dirty),
    .i_lru      (r_lru[w_idx]),
    .o_victim   (w_victim),
    .o_needs_wb (w_needs_wb)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (cpu_req) w_state_next = ST_COMPARE;
      ST_COMPARE: begin
        if (w_hit)           w_state_next = ST_IDLE;
        else if (w_needs_wb) w_state_next = ST_WRITEBACK;
        else                 w_state_next = ST_ALLOCATE;
      end
      ST_WRITEBACK: if (mem_wr_ack) w_state_next = ST_ALLOCATE;
      ST_ALLOCATE:  if (mem_rd_ack) w_state_next = ST_COMPARE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // Memory-side outputs decode straight from state so an ack may land in the first request cycle.
  always_comb begin
    cpu_busy   = (r_state != ST_IDLE);
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (r_state)
      ST_WRITEBACK: begin
        mem_wr_req = 1'b1;
        mem_addr   = {r_tag[r_victim][w_idx], w_idx, {OFF_BITS{1'b0}}};
        mem_wdata  = r_data[r_victim][w_idx];
      end
      ST_ALLOCATE: begin
        mem_rd_req = 1'b1;
        mem_addr   = {w_tag, w_idx, {OFF_BITS{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_valid[i] <= '0;
        r_dirty[i] <= '0;
      end
      r_lru       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_victim    <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
          end
        end
        ST_COMPARE: begin
          if (w_hit) begin
            r_cpu_ready  <= 1'b1;
            r_lru[w_idx] <= ~w_hit_way;
            if (r_we) r_dirty[w_hit_way][w_idx] <= 1'b1;
            else      r_cpu_rdata <= w_hit_line[w_off*WORD_W +: WORD_W];
          end else begin
            r_victim <= w_victim;
          end
        end
        ST_WRITEBACK: if (mem_wr_ack) r_dirty[r_victim][w_idx] <= 1'b0;
        ST_ALLOCATE: begin
          if (mem_rd_ack) begin
            r_valid[r_victim][w_idx] <= 1'b1;
            r_dirty[r_victim][w_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line data and tags carry no reset; they are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (r_state == ST_COMPARE && w_hit && r_we)
        r_data[w_hit_way][w_idx][w_off*WORD_W +: WORD_W] <= r_wdata;
      if (r_state == ST_ALLOCATE && mem_rd_ack) begin
        r_data[r_victim][w_idx] <= mem_rdata;
        r_tag[r_victim][w_idx]  <= w_tag;
      end
    end
  end

  assign cpu_ready = r_cpu_ready;
  assign cpu_rdata = r_cpu_rdata;

`ifdef CACHE_STATS_EN
  logic        r_filled;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // A hit that follows a refill for the same request is the tail of a miss, not a new hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_filled   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && cpu_req)       r_filled <= 1'b0;
      if (r_state == ST_ALLOCATE && mem_rd_ack) r_filled <= 1'b1;
      if (r_state == ST_COMPARE) begin
        if (w_hit && !r_filled && r_hit_cnt != '1) r_hit_cnt  <= r_hit_cnt + 32'd1;
        if (!w_hit && r_miss_cnt != '1)            r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/cache_sa2_wb.md
Name: cache_sa2_wb

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data/instruction cache between the CPU datapath and a line-wide memory port.
- Next generation of the lab cache:
  - configurable word width, set count and line length
  - explicit FSM with req/ack handshakes on both sides
  - true LRU per set
  - dirty-victim writeback before refill

Parameters:
- WORD_W, 16, data word width in bits.
- ADDR_W, 16, word-address width.
- SET_BITS, 1, log2 of set count (2 sets by default).
- OFF_BITS, 2, log2 of words per line (4 words by default); LINE_W = WORD_W << OFF_BITS.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low
- cpu_req  in  1  access request; accepted only when cpu_busy=0
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  word address: tag | index[SET_BITS] | offset[OFF_BITS]
- cpu_wdata  in  WORD_W  write data
- cpu_busy  out  1  high whenever the FSM is not IDLE
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  WORD_W  read data, valid while cpu_ready=1
- mem_rd_req  out  1  line fetch request, held until mem_rd_ack
- mem_wr_req  out  1  line writeback request, held until mem_wr_ack
- mem_addr  out  ADDR_W  line base address (offset bits 0)
- mem_wdata  out  LINE_W  victim line
- mem_rdata  in  LINE_W  fetched line, valid with mem_rd_ack
- mem_rd_ack  in  1  fetch complete (one-cycle pulse)
- mem_wr_ack  in  1  writeback complete (one-cycle pulse)

Behaviour:
- Line word order: offset k occupies bits [k*WORD_W +: WORD_W].
- State per set/way: valid, dirty, tag. One LRU bit per set; LRU=w means way w is least recently used.
- Reset (reset_n=0 at posedge):
  - all valid, dirty and LRU bits cleared
  - FSM returns to IDLE
  - cpu_ready, cpu_rdata, mem_rd_req, mem_wr_req, mem_addr, mem_wdata all 0
  - reset mid-operation aborts any transaction; dirty contents are discarded; acks arriving afterwards are ignored.
- IDLE: when cpu_req=1, register addr, we and wdata, then go to COMPARE. cpu_busy=0 only in IDLE. A cpu_req while busy is ignored, not queued.
- COMPARE:
  - Hit (valid and tag match in either way):
    - read: cpu_rdata = selected word
    - write: update the word and set dirty
    - point LRU at the other way, pulse cpu_ready, go to IDLE.
  - Hit latency: cpu_ready exactly 2 cycles after the accepting edge (1 cycle in COMPARE).
  - Both ways matching cannot occur by construction.
  - Miss, victim selection: first invalid way (way0 preferred), else the LRU way.
    - victim valid and dirty → WRITEBACK
    - otherwise → ALLOCATE
- WRITEBACK:
  - mem_wr_req=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line; all held stable.
  - On mem_wr_ack: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - mem_rd_req=1, mem_addr={req tag, index, 0}, held.
  - On mem_rd_ack: write mem_rdata into the victim way, set valid=1, dirty=0, tag=request tag; return to COMPARE, which then hits.
  - Miss latency = hit latency + memory cycles + 1.
- Never assert mem_rd_req and mem_wr_req together.
- An ack outside its matching state is ignored.
- An ack in the same cycle the request first rises is legal and is honoured.

Optional Feature:
- CACHE_STATS_EN defined:
  - adds 32-bit outputs hit_cnt and miss_cnt, reset to 0.
  - hit_cnt increments on a COMPARE hit that was not preceded by a fill for that request.
  - miss_cnt increments on each COMPARE miss.
  - Both saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg:
  - FSM state encoding (IDLE, COMPARE, WRITEBACK, ALLOCATE)
  - derived widths: TAG_W = ADDR_W-SET_BITS-OFF_BITS, LINE_W
  - address-field extract helpers
- One sub-module, cache_victim_sel: combinational. Inputs are valid[1:0] and lru; outputs are victim way and a needs-writeback flag (given dirty[1:0]).

Test Plan (defaults):
- After reset, read 0x0010 → mem_rd_req with mem_addr 0x0010; return line words {0xD,0xC,0xB,0xA} (offset0=0xA) → cpu_rdata 0x000A. Then read 0x0012 → hit, cpu_ready 2 cycles after accept, cpu_rdata 0x000C, no mem request.
- Write 0x0011 ← 0x1234 (hit) → no mem traffic; a read of 0x0011 returns 0x1234.
- Read 0x0000, read 0x0008 (both set 0, clean), re-read 0x0000, then read 0x0010 → no mem_wr_req; mem_rd_req 0x0010 replaces the way holding 0x0008; a subsequent read of 0x0008 misses.
- Write 0x0009 ← 0xBEEF, read 0x0000, read 0x0010 → mem_wr_req with mem_addr 0x0008 and mem_wdata word1=0xBEEF, then mem_rd_req 0x0010; cpu_rdata correct.
- Reset pulse while mem_wr_req=1 → next cycle mem_wr_req=0, cpu_busy=0; a late mem_wr_ack is ignored; read 0x0008 → miss.
- With CACHE_STATS_EN: sequence miss, hit, hit, miss → hit_cnt=2, miss_cnt=2; reset → both 0.
